// File: rtl/cache_line_bridge_if.sv
// Cache-side and memory-side signal bundles for cache_line_bridge.
// cmd_if: master = cache, slave = bridge. mem_if: master = bridge, slave = memory.
interface cache_line_bridge_cmd_if #(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int OFFSET_LENGTH = 4
);
    localparam int LINE_W = DATA_WIDTH * (2 ** OFFSET_LENGTH);

    logic                  cmd_valid;
    logic                  cmd_store;
    logic                  cmd_rready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LINE_W-1:0]     line_wdata;
    logic [LINE_W-1:0]     line_rdata;
    logic                  line_valid;
    logic                  line_ready;
    logic                  proto_err;

    modport master (
        output cmd_valid, cmd_store, cmd_rready, cmd_addr, line_wdata,
        input  line_rdata, line_valid, line_ready, proto_err
    );

    modport slave (
        input  cmd_valid, cmd_store, cmd_rready, cmd_addr, line_wdata,
        output line_rdata, line_valid, line_ready, proto_err
    );
endinterface

interface cache_line_bridge_mem_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wlast;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rlast;
    logic                  rready;

    modport master (
        output req_valid, req_write, req_addr, wdata, wvalid, wlast, bready, rready,
        input  req_ready, wready, bvalid, rdata, rvalid, rlast
    );

    modport slave (
        input  req_valid, req_write, req_addr, wdata, wvalid, wlast, bready, rready,
        output req_ready, wready, bvalid, rdata, rvalid, rlast
    );
endinterface

// File: rtl/cache_line_bridge.sv
// Serialises one cache line fill/writeback into a BEATS-long memory burst; one command in flight.
// Zero-wait: fill pulse 18 cycles after capture, writeback ack 19; every memory stall adds one cycle.
module cache_line_bridge #(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int OFFSET_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    cache_line_bridge_cmd_if.slave   cache,
    cache_line_bridge_mem_if.master  mem
);
    localparam int BEATS  = 2 ** OFFSET_LENGTH;
    localparam int LINE_W = DATA_WIDTH * BEATS;
    localparam logic [ADDR_WIDTH-1:0]    OFF_MASK = ADDR_WIDTH'(BEATS - 1);
    localparam logic [OFFSET_LENGTH-1:0] CNT_LAST = OFFSET_LENGTH'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_DATA,
        S_RD_DONE,
        S_WR_REQ,
        S_WR_DATA,
        S_WR_RESP,
        S_WR_DONE
    } state_t;

    state_t                   r_state;
    logic [OFFSET_LENGTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [LINE_W-1:0]        r_wbuf;
    logic [LINE_W-1:0]        r_rdata;
    logic                     r_req_valid;
    logic                     r_req_write;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic                     r_wvalid;
    logic                     r_wlast;
    logic                     r_bready;
    logic                     r_rready;
    logic                     r_line_valid;
    logic                     r_line_ready;
    logic                     r_proto_err;

    logic [ADDR_WIDTH-1:0]    w_aligned_addr;
    logic [OFFSET_LENGTH-1:0] w_cnt_nxt;
    logic                     w_cnt_last;
    logic [DATA_WIDTH-1:0]    w_wbeat_nxt;

    assign w_aligned_addr = cache.cmd_addr & ~OFF_MASK;
    assign w_cnt_nxt      = r_cnt + 1'b1;
    assign w_cnt_last     = (r_cnt == CNT_LAST);
    assign w_wbeat_nxt    = r_wbuf[int'(w_cnt_nxt)*DATA_WIDTH +: DATA_WIDTH];

    // Outputs are loaded on the transition into the state that owns them,
    // so every output is a flop and never a combinational function of an input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_rdata      <= '0;
            r_req_valid  <= 1'b0;
            r_req_write  <= 1'b0;
            r_wdata      <= '0;
            r_wvalid     <= 1'b0;
            r_wlast      <= 1'b0;
            r_bready     <= 1'b0;
            r_rready     <= 1'b0;
            r_line_valid <= 1'b0;
            r_line_ready <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_line_valid <= 1'b0;
            r_line_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cache.cmd_valid && cache.cmd_store) begin
                        r_addr      <= w_aligned_addr;
                        r_wbuf      <= cache.line_wdata;
                        r_req_valid <= 1'b1;
                        r_req_write <= 1'b1;
                        r_state     <= S_WR_REQ;
                    end else if (cache.cmd_valid && cache.cmd_rready) begin
                        r_addr      <= w_aligned_addr;
                        r_req_valid <= 1'b1;
                        r_req_write <= 1'b0;
                        r_state     <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (mem.req_ready) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_rready    <= 1'b1;
                        r_state     <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (mem.rvalid) begin
                        r_rdata[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH] <= mem.rdata;
                        r_cnt <= w_cnt_nxt;
                        // rlast is only advisory; the beat counter decides completion.
                        if (mem.rlast != w_cnt_last) begin
                            r_proto_err <= 1'b1;
                        end
                        if (w_cnt_last) begin
                            r_rready     <= 1'b0;
                            r_line_valid <= 1'b1;
                            r_state      <= S_RD_DONE;
                        end
                    end
                end
                S_RD_DONE: begin
                    r_state <= S_IDLE;
                end
                S_WR_REQ: begin
                    if (mem.req_ready) begin
                        r_req_valid <= 1'b0;
                        r_req_write <= 1'b0;
                        r_cnt       <= '0;
                        r_wvalid    <= 1'b1;
                        r_wdata     <= r_wbuf[DATA_WIDTH-1:0];
                        r_wlast     <= (OFFSET_LENGTH == 0);
                        r_state     <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (mem.wready) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_last) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_wdata  <= '0;
                            r_bready <= 1'b1;
                            r_state  <= S_WR_RESP;
                        end else begin
                            r_wdata <= w_wbeat_nxt;
                            r_wlast <= (w_cnt_nxt == CNT_LAST);
                        end
                    end
                end
                S_WR_RESP: begin
                    if (mem.bvalid) begin
                        r_bready     <= 1'b0;
                        r_line_ready <= 1'b1;
                        r_state      <= S_WR_DONE;
                    end
                end
                S_WR_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.req_valid    = r_req_valid;
    assign mem.req_write    = r_req_write;
    assign mem.req_addr     = r_addr;
    assign mem.wdata        = r_wdata;
    assign mem.wvalid       = r_wvalid;
    assign mem.wlast        = r_wlast;
    assign mem.bready       = r_bready;
    assign mem.rready       = r_rready;
    assign cache.line_rdata = r_rdata;
    assign cache.line_valid = r_line_valid;
    assign cache.line_ready = r_line_ready;
    assign cache.proto_err  = r_proto_err;
endmodule

// File: tb/tb_cache_line_bridge.sv
// Scoreboarded bench for cache_line_bridge: directed commands, a reactive memory model,
// and a negedge monitor that pops expected bursts and completions from a queue.
module tb_cache_line_bridge;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int OL    = 4;
    localparam int BEATS = 16;
    localparam int LW    = DW * BEATS;

    localparam int K_REQ   = 0;
    localparam int K_WBEAT = 1;
    localparam int K_FILL  = 2;
    localparam int K_WDONE = 3;

    typedef struct {
        int           kind;
        logic [127:0] dat;
        logic [LW-1:0] line;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_line_bridge_cmd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL)) cif();
    cache_line_bridge_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif();

    cache_line_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL)) dut (
        .clk   (clk),
        .reset (reset),
        .cache (cif),
        .mem   (mif)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    int          rlast_beat = BEATS - 1;
    logic [63:0] rd_base = 64'h0;
    bit          wr_stall = 1'b0;

    initial begin
        bit rd_active, hs_req, req_wr, hs_r, hs_wl, hs_b, rst_s;
        int rd_beat;
        rd_active = 0;
        rd_beat   = 0;
        mif.req_ready = 1'b0;
        mif.rvalid    = 1'b0;
        mif.rdata     = '0;
        mif.rlast     = 1'b0;
        mif.wready    = 1'b0;
        mif.bvalid    = 1'b0;
        forever begin
            @(negedge clk);
            hs_req = mif.req_valid & mif.req_ready;
            req_wr = mif.req_write;
            hs_r   = mif.rvalid & mif.rready;
            hs_wl  = mif.wvalid & mif.wready & mif.wlast;
            hs_b   = mif.bvalid & mif.bready;
            rst_s  = reset;
            @(posedge clk);
            #1;
            if (rst_s) begin
                rd_active  = 0;
                rd_beat    = 0;
                mif.bvalid = 1'b0;
            end else begin
                if (hs_req && !req_wr) begin
                    rd_active = 1;
                    rd_beat   = 0;
                end
                if (hs_r) begin
                    rd_beat++;
                    if (rd_beat == BEATS) rd_active = 0;
                end
                if (hs_wl) mif.bvalid = 1'b1;
                if (hs_b) mif.bvalid = 1'b0;
            end
            mif.req_ready = 1'b1;
            mif.rvalid    = rd_active;
            mif.rdata     = rd_base + 64'(rd_beat);
            mif.rlast     = rd_active && (rd_beat == rlast_beat);
            mif.wready    = wr_stall ? cyc[0] : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    int last_b_cyc = -100;

    task automatic observe(input int kind, input logic [127:0] act, input logic [LW-1:0] line);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected nothing (cycle %0d)", kind, act, cyc);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", kind, e.kind);
        case (kind)
            K_REQ:   chk("mem_req", act, e.dat);
            K_WBEAT: chk("wbeat_wlast_wdata", act, e.dat);
            K_FILL: begin
                for (int k = 0; k < BEATS; k++)
                    chk($sformatf("fill_word%0d", k), line[k*DW +: DW], e.line[k*DW +: DW]);
                if (e.cyc >= 0) chk("fill_cycle", cyc, e.cyc);
            end
            default: begin
                if (e.cyc >= 0) chk("wdone_cycle", cyc, e.cyc);
                chk("wdone_after_b", cyc, last_b_cyc + 1);
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (mif.bvalid && mif.bready) last_b_cyc = cyc;
        if (mif.req_valid && mif.req_ready)
            observe(K_REQ, {63'b0, mif.req_write, mif.req_addr}, '0);
        if (mif.wvalid && mif.wready)
            observe(K_WBEAT, {63'b0, mif.wlast, mif.wdata}, '0);
        if (cif.line_valid) observe(K_FILL, '0, cif.line_rdata);
        if (cif.line_ready) observe(K_WDONE, '0, '0);
    end

    // ---------------- expectation helpers ----------------
    task automatic exp_req(input bit wr, input logic [63:0] a);
        exp_t e;
        e.kind = K_REQ; e.dat = {63'b0, wr, a}; e.line = '0; e.cyc = -1;
        sb.push_back(e);
    endtask

    task automatic exp_fill(input logic [63:0] base, input int c);
        exp_t e;
        e.kind = K_FILL; e.dat = '0; e.cyc = c;
        for (int k = 0; k < BEATS; k++) e.line[k*DW +: DW] = base + 64'(k);
        sb.push_back(e);
    endtask

    task automatic exp_wbeats(input logic [LW-1:0] wd, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.kind = K_WBEAT; e.line = '0; e.cyc = -1;
            e.dat = {63'b0, (k == BEATS - 1), wd[k*DW +: DW]};
            sb.push_back(e);
        end
    endtask

    task automatic exp_wdone(input int c);
        exp_t e;
        e.kind = K_WDONE; e.dat = '0; e.line = '0; e.cyc = c;
        sb.push_back(e);
    endtask

    // ---------------- cache-side drivers (called at posedge + 1) ----------------
    task automatic start_cmd(input bit st, input logic [63:0] a, input logic [LW-1:0] wd, output int c0);
        cif.cmd_valid  = 1'b1;
        cif.cmd_store  = st;
        cif.cmd_rready = !st;
        cif.cmd_addr   = a;
        cif.line_wdata = wd;
        c0 = cyc;
    endtask

    task automatic stop_cmd();
        cif.cmd_valid  = 1'b0;
        cif.cmd_store  = 1'b0;
        cif.cmd_rready = 1'b0;
    endtask

    task automatic wait_done(input bit wr, input int budget);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            seen = wr ? cif.line_ready : cif.line_valid;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no completion pulse expected one within %0d cycles", budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_valid"}, mif.req_valid, 0);
        chk({tag, "_req_write"}, mif.req_write, 0);
        chk({tag, "_req_addr"}, mif.req_addr, 0);
        chk({tag, "_wvalid"}, mif.wvalid, 0);
        chk({tag, "_wlast"}, mif.wlast, 0);
        chk({tag, "_wdata"}, mif.wdata, 0);
        chk({tag, "_bready"}, mif.bready, 0);
        chk({tag, "_rready"}, mif.rready, 0);
        chk({tag, "_line_valid"}, cif.line_valid, 0);
        chk({tag, "_line_ready"}, cif.line_ready, 0);
        chk({tag, "_proto_err"}, cif.proto_err, 0);
        chk({tag, "_line_rdata_nonzero"}, (cif.line_rdata != '0), 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int c0, c1, seen;
        logic [LW-1:0] wd;
        cif.cmd_valid  = 1'b0;
        cif.cmd_store  = 1'b0;
        cif.cmd_rready = 1'b0;
        cif.cmd_addr   = '0;
        cif.line_wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Fill, zero-wait memory
        rd_base = 64'hA0;
        exp_req(1'b0, 64'h1230);
        start_cmd(1'b0, 64'h1234, '0, c0);
        exp_fill(64'hA0, c0 + 18);
        wait_done(1'b0, 100);
        stop_cmd();
        repeat (3) @(negedge clk);
        chk("fill_proto_err", cif.proto_err, 0);
        chk("fill_rdata_holds_w3", cif.line_rdata[3*DW +: DW], 64'hA3);
        next_cycle();

        // Writeback with wready low every other cycle
        wr_stall = 1'b1;
        for (int k = 0; k < BEATS; k++) wd[k*DW +: DW] = 64'(k);
        exp_req(1'b1, 64'h5670);
        exp_wbeats(wd, BEATS);
        exp_wdone(-1);
        start_cmd(1'b1, 64'h5678, wd, c0);
        wait_done(1'b1, 200);
        stop_cmd();
        wr_stall = 1'b0;
        next_cycle();

        // Fill immediately followed by a writeback
        rd_base = 64'hB0;
        exp_req(1'b0, 64'h2000);
        start_cmd(1'b0, 64'h2000, '0, c0);
        exp_fill(64'hB0, c0 + 18);
        wait_done(1'b0, 100);
        for (int k = 0; k < BEATS; k++) wd[k*DW +: DW] = 64'h100 + 64'(k);
        exp_req(1'b1, 64'h3000);
        exp_wbeats(wd, BEATS);
        start_cmd(1'b1, 64'h3008, wd, c1);
        exp_wdone(c0 + 38);
        wait_done(1'b1, 100);
        stop_cmd();
        next_cycle();

        // Early rlast on beat 7
        rd_base = 64'hC0;
        rlast_beat = 7;
        exp_req(1'b0, 64'h40);
        start_cmd(1'b0, 64'h4F, '0, c0);
        exp_fill(64'hC0, c0 + 18);
        wait_done(1'b0, 100);
        stop_cmd();
        rlast_beat = BEATS - 1;
        @(negedge clk);
        chk("early_rlast_proto_err", cif.proto_err, 1);
        repeat (5) @(negedge clk);
        chk("proto_err_sticky", cif.proto_err, 1);
        next_cycle();

        // Reset during write beat 5
        for (int k = 0; k < BEATS; k++) wd[k*DW +: DW] = 64'hF00 + 64'(k);
        exp_req(1'b1, 64'h7770);
        exp_wbeats(wd, 6);
        start_cmd(1'b1, 64'h7777, wd, c0);
        repeat (7) next_cycle();
        reset = 1'b1;
        stop_cmd();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        next_cycle();

        // Fill after the abandoned writeback
        rd_base = 64'hD0;
        exp_req(1'b0, 64'h9990);
        start_cmd(1'b0, 64'h999F, '0, c0);
        exp_fill(64'hD0, c0 + 18);
        wait_done(1'b0, 100);
        stop_cmd();
        @(negedge clk);
        chk("post_rst_proto_err", cif.proto_err, 0);
        next_cycle();

        // Fill command without rready must be ignored
        cif.cmd_valid  = 1'b1;
        cif.cmd_store  = 1'b0;
        cif.cmd_rready = 1'b0;
        cif.cmd_addr   = 64'h500;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mif.req_valid) seen++;
        end
        chk("ignored_cmd_req_cycles", seen, 0);
        next_cycle();
        stop_cmd();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
